// File: rtl/sub_pkg.sv
// sub_pkg: shared FSM encoding and digit-count helper for serial_sub.
package sub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int digit_count(input int width, input int digit);
    return width / digit;
  endfunction
endpackage

// File: rtl/fs_cell.sv
// fs_cell: single-bit combinational full subtractor (d = x - y - bin).
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = (~x & (y | bin)) | (y & bin);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: multi-cycle WIDTH-bit subtractor, DIGIT bits per clock with start/busy/done handshake.
// Optional signed-overflow output Ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub import sub_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borr
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             Ovf
`endif
);
  localparam int N  = digit_count(WIDTH, DIGIT);
  localparam int CW = N > 1 ? $clog2(N) : 1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic bor_q, bor_d, borr_q, borr_d;
  logic [DIGIT:0] c;
  logic [DIGIT-1:0] d;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [WIDTH-1:0] r_nx;
  logic accept, last;
  assign c[0] = bor_q;
  genvar i;
  for (i = 0; i < DIGIT; i++) begin : g_cell
    fs_cell u_cell (.x(a_q[i]), .y(b_q[i]), .bin(c[i]), .d(d[i]), .bout(c[i+1]));
  end
  // new digit enters at the MSB so after N digits the LSB digit sits at the bottom
  assign cat    = {d, r_q};
  assign r_nx   = cat[WIDTH+DIGIT-1:DIGIT];
  assign accept = start && (state_q != RUN);
  assign last   = cnt_q == CW'(N - 1);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    bor_d   = bor_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    borr_d  = borr_q;
    if (accept) begin
      a_d     = A;
      b_d     = B;
      r_d     = '0;
      bor_d   = Bin;
      cnt_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      a_d   = a_q >> DIGIT;
      b_d   = b_q >> DIGIT;
      r_d   = r_nx;
      bor_d = c[DIGIT];
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        diff_d  = r_nx;
        borr_d  = c[DIGIT];
        state_d = DONE;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      bor_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      borr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      bor_q   <= bor_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      borr_q  <= borr_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign Diff = diff_q;
  assign Borr = borr_q;
`ifdef SERIAL_SUB_OVF_EN
  // operand sign bits are shifted out during RUN, so keep them separately
  logic sa_q, sb_q, ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      sa_q <= A[WIDTH-1];
      sb_q <= B[WIDTH-1];
    end else if (state_q == RUN && last) begin
      ovf_q <= (sa_q != sb_q) && (r_nx[WIDTH-1] != sa_q);
    end
  end
  assign Ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub at WIDTH=8, DIGIT=2.
module tb_serial_sub;
  localparam int W = 8;
  localparam int DG = 2;
  localparam int N = W / DG;
  typedef struct packed {logic [W-1:0] d; logic b; logic o;} exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, Bin = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic busy, done, Borr;
  logic [W-1:0] Diff;
`ifdef SERIAL_SUB_OVF_EN
  logic Ovf;
`endif
  exp_t q[$];
  int errors = 0, checks = 0;
  serial_sub #(.WIDTH(W), .DIGIT(DG)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .Diff(Diff), .Borr(Borr)
`ifdef SERIAL_SUB_OVF_EN
    , .Ovf(Ovf)
`endif
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    exp_t e;
    int s;
    s = int'(a) - int'(b) - int'(bin);
    if (s < 0) s = s + 256;
    e.d = s[W-1:0];
    e.b = int'(a) < int'(b) + int'(bin);
    e.o = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
    return e;
  endfunction
  // caller sits #1 after an edge with the DUT idle or in DONE
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    A = a; B = b; Bin = bin; start = 1'b1;
    q.push_back(model(a, b, bin));
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic wait_done(input string name, output int lat);
    lat = 0;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    checks++;
    if (lat == 0) begin errors++; $display("FAIL %s timeout: done=%b want 1", name, done); end
  endtask
  task automatic check_result(input string name);
    exp_t e;
    checks++;
    if (q.size() == 0) begin errors++; $display("FAIL %s scoreboard: got empty queue want entry", name); return; end
    e = q.pop_front();
    checks++;
    if (Diff !== e.d) begin errors++; $display("FAIL %s diff: got %h want %h", name, Diff, e.d); end
    checks++;
    if (Borr !== e.b) begin errors++; $display("FAIL %s borr: got %b want %b", name, Borr, e.b); end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (Ovf !== e.o) begin errors++; $display("FAIL %s ovf: got %b want %b", name, Ovf, e.o); end
`endif
  endtask
  task automatic check_lat(input string name, input int lat, input int want);
    checks++;
    if (lat !== want) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, want); end
  endtask
  task automatic test_reset();
    #12;
    checks++;
    if ({busy, done, Diff, Borr} !== '0) begin errors++; $display("FAIL reset outputs: got busy=%b done=%b diff=%h borr=%b want 0", busy, done, Diff, Borr); end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (Ovf !== 1'b0) begin errors++; $display("FAIL reset ovf: got %b want 0", Ovf); end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_basic();
    int lat;
    start_op(8'h00, 8'h01, 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic busy: got %b want 1", busy); end
    wait_done("basic", lat);
    check_lat("basic", lat, N);
    check_result("basic");
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic pulse: got done=%b want 0", done); end
  endtask
  task automatic test_back_to_back();
    int lat;
    start_op(8'h55, 8'h55, 1'b1);
    wait_done("b2b_first", lat);
    check_result("b2b_first");
    start_op(8'hA0, 8'h20, 1'b0);
    wait_done("b2b_second", lat);
    check_lat("b2b_gap", lat + 1, N + 1);
    check_result("b2b_second");
    @(posedge clk); #1;
  endtask
  task automatic test_start_ignored();
    int lat, pulses;
    start_op(8'h30, 8'h10, 1'b0);
    A = 8'hFF; B = 8'h00; Bin = 1'b1; start = 1'b1;
    repeat (N - 1) begin @(posedge clk); #1; end
    start = 1'b0;
    wait_done("ignored", lat);
    check_lat("ignored", lat, 1);
    check_result("ignored");
    pulses = 0;
    repeat (N + 2) begin @(posedge clk); #1; if (done || busy) pulses++; end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL ignored extra: got %0d active cycles want 0", pulses); end
  endtask
  task automatic test_reset_mid();
    int lat;
    start_op(8'h0F, 8'h03, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, Diff, Borr} !== '0) begin errors++; $display("FAIL midreset outputs: got busy=%b done=%b diff=%h borr=%b want 0", busy, done, Diff, Borr); end
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL midreset done: got %b want 0", done); end
    start_op(8'hC3, 8'h3C, 1'b1);
    wait_done("after_reset", lat);
    check_lat("after_reset", lat, N);
    check_result("after_reset");
    @(posedge clk); #1;
  endtask
  task automatic test_random();
    int lat;
    for (int n = 0; n < 40; n++) begin
      start_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      wait_done("random", lat);
      check_lat("random", lat, N);
      check_result("random");
      if (n % 2 == 0) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
  endtask
  task automatic test_ovf();
    int lat;
    start_op(8'h80, 8'h01, 1'b0);
    wait_done("ovf_neg", lat);
    check_result("ovf_neg");
    start_op(8'h7F, 8'hFF, 1'b0);
    wait_done("ovf_pos", lat);
    check_result("ovf_pos");
    start_op(8'h10, 8'h01, 1'b0);
    wait_done("ovf_none", lat);
    check_result("ovf_none");
    @(posedge clk); #1;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    test_ovf();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
